// File: rtl/core_bus_fabric.sv
// rtl/core_bus_fabric.sv - Wishbone master-to-NUM_SLV slave decode fabric; optional BUS_TIMEOUT_EN access timeout
module core_bus_fabric #(
    parameter int                    NUM_SLV     = 4,
    parameter logic [NUM_SLV*32-1:0] SLV_BASE    = '0,
    parameter logic [NUM_SLV*32-1:0] SLV_MASK    = '0,
    parameter int                    TIMEOUT_CYC = 1024
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic                  m_cyc,
    input  logic                  m_stb,
    input  logic                  m_we,
    input  logic [31:0]           m_adr,
    input  logic [31:0]           m_dat_w,
    input  logic [3:0]            m_sel,
    output logic [31:0]           m_dat_r,
    output logic                  m_ack,
    output logic                  m_err,
    output logic [NUM_SLV-1:0]    s_stb,
    output logic                  s_we,
    output logic [31:0]           s_adr,
    output logic [31:0]           s_dat_w,
    output logic [3:0]            s_sel,
    input  logic [NUM_SLV*32-1:0] s_dat_r,
    input  logic [NUM_SLV-1:0]    s_ack,
    output logic [3:0]            cur_slv
);

    if (NUM_SLV < 1 || NUM_SLV > 16 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_cfg
        $error("core_bus_fabric: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

    state_t      state, state_nxt;
    logic        dec_hit;
    logic [3:0]  dec_idx;
    logic        sel_ack;
    logic [31:0] sel_dat;
    logic        timeout_hit;

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = 4'd0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((m_adr & SLV_MASK[32*i +: 32]) == (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32])) begin
                dec_hit = 1'b1;
                dec_idx = 4'(i);
            end
        end
    end

    always_comb begin
        sel_ack = 1'b0;
        sel_dat = 32'h0;
        s_stb   = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (cur_slv == 4'(i)) begin
                sel_ack  = s_ack[i];
                sel_dat  = s_dat_r[32*i +: 32];
                s_stb[i] = (state == ACCESS);
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    logic [15:0] to_cnt;

    always_ff @(posedge sys_clk) begin
        if (reset || state != ACCESS) begin
            to_cnt <= 16'd0;
        end else begin
            to_cnt <= to_cnt + 16'd1;
        end
    end

    assign timeout_hit = (to_cnt == 16'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort beats a same-cycle ack; an ack beats a same-cycle timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (m_cyc && m_stb) state_nxt = dec_hit ? ACCESS : ERR;
            ACCESS: begin
                if (!m_cyc)           state_nxt = IDLE;
                else if (sel_ack)     state_nxt = RESP;
                else if (timeout_hit) state_nxt = ERR;
            end
            RESP:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            m_dat_r <= 32'h0;
            s_we    <= 1'b0;
            s_adr   <= 32'h0;
            s_dat_w <= 32'h0;
            s_sel   <= 4'h0;
            cur_slv <= 4'd0;
        end else begin
            if (state == IDLE && m_cyc && m_stb) begin
                s_we    <= m_we;
                s_adr   <= m_adr;
                s_dat_w <= m_dat_w;
                s_sel   <= m_sel;
                cur_slv <= dec_hit ? dec_idx : 4'd0;
            end
            if (state_nxt == RESP) begin
                m_dat_r <= sel_dat;
            end else if (state_nxt == ERR) begin
                m_dat_r <= 32'h0;
            end
        end
    end

    assign m_ack = (state == RESP);
    assign m_err = (state == ERR);

endmodule

// File: tb/tb_core_bus_fabric.sv
// tb/tb_core_bus_fabric.sv - directed self-checking bench for core_bus_fabric
module tb_core_bus_fabric;

    localparam int NS = 4;
    localparam logic [NS*32-1:0] BASE  = {32'h0, 32'h03400000, 32'h03300000, 32'h03400500};
    localparam logic [NS*32-1:0] MASK  = {32'h0, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFFFF00};
    localparam logic [NS*32-1:0] MASK2 = {32'hFFFFFFFF, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFFFF00};

    logic           sys_clk = 1'b0;
    logic           reset;
    logic           m_cyc, m_stb, m_we;
    logic [31:0]    m_adr, m_dat_w;
    logic [3:0]     m_sel;
    logic [NS*32-1:0] s_dat_r;
    logic [NS-1:0]  s_ack;

    logic [31:0]    m_dat_r, s_adr, s_dat_w;
    logic           m_ack, m_err, s_we;
    logic [NS-1:0]  s_stb;
    logic [3:0]     s_sel, cur_slv;

    logic [31:0]    m_dat_r2, s_adr2, s_dat_w2;
    logic           m_ack2, m_err2, s_we2;
    logic [NS-1:0]  s_stb2;
    logic [3:0]     s_sel2, cur_slv2;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses;

    always #5 sys_clk = ~sys_clk;

    core_bus_fabric #(.NUM_SLV(NS), .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT_CYC(8)) u_dut (
        .sys_clk(sys_clk), .reset(reset), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
        .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel), .m_dat_r(m_dat_r), .m_ack(m_ack),
        .m_err(m_err), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w),
        .s_sel(s_sel), .s_dat_r(s_dat_r), .s_ack(s_ack), .cur_slv(cur_slv)
    );

    // Same map, but slave3 only matches address 0: no default route.
    core_bus_fabric #(.NUM_SLV(NS), .SLV_BASE(BASE), .SLV_MASK(MASK2), .TIMEOUT_CYC(8)) u_dut_nodef (
        .sys_clk(sys_clk), .reset(reset), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
        .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel), .m_dat_r(m_dat_r2), .m_ack(m_ack2),
        .m_err(m_err2), .s_stb(s_stb2), .s_we(s_we2), .s_adr(s_adr2), .s_dat_w(s_dat_w2),
        .s_sel(s_sel2), .s_dat_r(s_dat_r), .s_ack(s_ack), .cur_slv(cur_slv2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic start(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_adr = adr; m_dat_w = dat; m_sel = 4'hF;
    endtask

    task automatic idle_master();
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_adr = 32'h0; m_dat_w = 32'h0; m_sel = 4'h0;
    endtask

    initial begin
        reset = 1'b1;
        idle_master();
        s_ack = '0;
        s_dat_r = {32'hDEF0DEF0, 32'h22223333, 32'hA1A1A1A1, 32'h12345678};
        step(); step();
        check("rst_s_stb", 32'(s_stb), 32'h0);
        check("rst_m_ack", 32'(m_ack), 32'h0);
        check("rst_m_err", 32'(m_err), 32'h0);
        check("rst_m_dat_r", m_dat_r, 32'h0);
        check("rst_s_adr", s_adr, 32'h0);
        check("rst_cur_slv", 32'(cur_slv), 32'h0);
        reset = 1'b0;
        step();

        // Read XBUS, zero wait: XBUS wins over the overlapping CLIO region.
        start(1'b0, 32'h03400504, 32'h0);
        step();
        check("rd0_s_stb_c1", 32'(s_stb), 32'h1);
        check("rd0_cur_slv", 32'(cur_slv), 32'h0);
        check("rd0_m_ack_c1", 32'(m_ack), 32'h0);
        s_ack = 4'b0001;
        step();
        check("rd0_m_ack_c2", 32'(m_ack), 32'h1);
        check("rd0_m_dat_r", m_dat_r, 32'h12345678);
        check("rd0_s_stb_c2", 32'(s_stb), 32'h0);
        s_ack = '0;
        idle_master();
        step();
        check("rd0_m_ack_c3", 32'(m_ack), 32'h0);

        // Write MADAM, three wait states; master bus is scribbled after cycle 0.
        start(1'b1, 32'h03300010, 32'hCAFEF00D);
        pulses = 0;
        step();
        m_adr = 32'hFFFFFFFC; m_dat_w = 32'h0BADBEEF; m_we = 1'b0; m_sel = 4'h1;
        for (int c = 1; c <= 4; c++) begin
            check("wr1_s_stb", 32'(s_stb), 32'h2);
            check("wr1_s_adr", s_adr, 32'h03300010);
            check("wr1_s_dat_w", s_dat_w, 32'hCAFEF00D);
            check("wr1_s_we", 32'(s_we), 32'h1);
            check("wr1_s_sel", 32'(s_sel), 32'hF);
            check("wr1_no_early_ack", 32'(m_ack), 32'h0);
            if (c == 4) s_ack = 4'b0010;
            step();
        end
        s_ack = '0;
        m_cyc = 1'b0; m_stb = 1'b0;
        check("wr1_m_ack_c5", 32'(m_ack), 32'h1);
        check("wr1_m_dat_r", m_dat_r, 32'hA1A1A1A1);
        check("wr1_s_adr_c5", s_adr, 32'h03300010);
        for (int c = 0; c < 3; c++) begin
            pulses += int'(m_ack);
            check("wr1_no_err", 32'(m_err), 32'h0);
            step();
        end
        check("wr1_one_pulse", 32'(pulses), 32'h1);

        // Unmapped-by-region read: default slave on u_dut, error on u_dut_nodef.
        start(1'b0, 32'h00001000, 32'h0);
        step();
        check("rd3_s_stb", 32'(s_stb), 32'h8);
        check("rd3_cur_slv", 32'(cur_slv), 32'h3);
        check("nd_m_err_c1", 32'(m_err2), 32'h1);
        check("nd_m_ack_c1", 32'(m_ack2), 32'h0);
        check("nd_m_dat_r", m_dat_r2, 32'h0);
        check("nd_s_stb", 32'(s_stb2), 32'h0);
        s_ack = 4'b1000;
        step();
        check("rd3_m_ack", 32'(m_ack), 32'h1);
        check("rd3_m_dat_r", m_dat_r, 32'hDEF0DEF0);
        check("nd_m_err_c2", 32'(m_err2), 32'h0);
        s_ack = '0;
        idle_master();
        step();

        // Abort to CLIO with a late ack after the drop.
        start(1'b0, 32'h03400010, 32'h0);
        step();
        check("ab_s_stb_c1", 32'(s_stb), 32'h4);
        step();
        check("ab_s_stb_c2", 32'(s_stb), 32'h4);
        idle_master();
        step();
        check("ab_s_stb_c3", 32'(s_stb), 32'h0);
        s_ack = 4'b0100;
        for (int c = 3; c < 6; c++) begin
            check("ab_no_ack", 32'(m_ack), 32'h0);
            check("ab_no_err", 32'(m_err), 32'h0);
            step();
            s_ack = '0;
        end
        check("ab_m_dat_r_held", m_dat_r, 32'hDEF0DEF0);

        // MADAM never acks.
        start(1'b0, 32'h03300020, 32'h0);
        step();
`ifdef BUS_TIMEOUT_EN
        for (int c = 1; c <= 8; c++) begin
            check("to_s_stb", 32'(s_stb), 32'h2);
            check("to_no_err", 32'(m_err), 32'h0);
            step();
        end
        check("to_m_err", 32'(m_err), 32'h1);
        check("to_m_ack", 32'(m_ack), 32'h0);
        check("to_s_stb_err", 32'(s_stb), 32'h0);
        check("to_m_dat_r", m_dat_r, 32'h0);
        idle_master();
        step();
        check("to_m_err_after", 32'(m_err), 32'h0);
        check("to_s_stb_after", 32'(s_stb), 32'h0);
`else
        for (int c = 1; c <= 100; c++) begin
            check("nto_s_stb", 32'(s_stb), 32'h2);
            check("nto_no_err", 32'(m_err), 32'h0);
            step();
        end
        idle_master();
        step();
        check("nto_s_stb_abort", 32'(s_stb), 32'h0);
`endif
        step();

        // Reset during ACCESS, ack racing the reset is dropped.
        start(1'b0, 32'h03400020, 32'h0);
        step();
        check("rs_s_stb_c1", 32'(s_stb), 32'h4);
        reset = 1'b1;
        s_ack = 4'b0100;
        step();
        check("rs_s_stb", 32'(s_stb), 32'h0);
        check("rs_m_ack", 32'(m_ack), 32'h0);
        check("rs_m_err", 32'(m_err), 32'h0);
        check("rs_cur_slv", 32'(cur_slv), 32'h0);
        check("rs_m_dat_r", m_dat_r, 32'h0);
        reset = 1'b0;
        s_ack = '0;
        idle_master();
        step();
        start(1'b0, 32'h03400020, 32'h0);
        step();
        check("rs2_s_stb", 32'(s_stb), 32'h4);
        check("rs2_cur_slv", 32'(cur_slv), 32'h2);
        s_ack = 4'b0100;
        step();
        check("rs2_m_ack", 32'(m_ack), 32'h1);
        check("rs2_m_dat_r", m_dat_r, 32'h22223333);
        s_ack = '0;
        idle_master();
        step();
        check("rs2_m_ack_end", 32'(m_ack), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_bus_fabric.md
Name: core_bus_fabric

Overview:
- Parametrised successor to the hard-wired CPU-side chip-select/read-mux in the core top level.
- Decodes one Wishbone master (ZAP CPU) onto NUM_SLV slave ports (MADAM, CLIO, XBUS, default memory, ...) using per-slave base/mask regions, resolved by priority.
- Registers the routing decision and the returned data, and generates the master ack itself.
- Reports an error for unmapped accesses and, optionally, for timed-out accesses.

Parameters:
- NUM_SLV, 4, number of slave ports (1..16).
- SLV_BASE, {NUM_SLV{32'h0}}, flattened NUM_SLV*32 base addresses; slave i uses bits [32*i+31:32*i].
- SLV_MASK, {NUM_SLV{32'h0}}, flattened NUM_SLV*32 compare masks. Slave i matches when (m_adr & mask_i) == (base_i & mask_i).
- TIMEOUT_CYC, 1024, cycles in ACCESS without a slave ack before error (only with BUS_TIMEOUT_EN); valid range 2..65535.

Ports:
- sys_clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- m_cyc  in  1  master cycle.
- m_stb  in  1  master strobe.
- m_we  in  1  master write enable.
- m_adr  in  32  master byte address.
- m_dat_w  in  32  master write data.
- m_sel  in  4  master byte selects.
- m_dat_r  out  32  read data to master, registered.
- m_ack  out  1  one-cycle ack pulse to master.
- m_err  out  1  one-cycle error pulse to master (instead of m_ack).
- s_stb  out  NUM_SLV  one-hot slave strobe.
- s_we  out  1  broadcast write enable, latched.
- s_adr  out  32  broadcast address, latched.
- s_dat_w  out  32  broadcast write data, latched.
- s_sel  out  4  broadcast byte selects, latched.
- s_dat_r  in  NUM_SLV*32  flattened slave read data.
- s_ack  in  NUM_SLV  slave acks.
- cur_slv  out  4  index of the slave currently selected, for debug.

Behaviour:
- Reset values: all outputs 0; state IDLE; timeout counter 0.
- States: IDLE, ACCESS, RESP, ERR.
- IDLE:
  - When m_cyc & m_stb, latch m_adr/m_we/m_dat_w/m_sel onto s_* and latch the decode result.
  - Match found: go to ACCESS.
  - No slave matches: go to ERR.
- Decode priority: lowest matching index wins. Mask 0 is catch-all, so a catch-all placed at the highest index gives default routing.
- ACCESS:
  - s_stb[cur_slv]=1; all other s_stb bits 0.
  - When s_ack[cur_slv]=1: capture s_dat_r[cur_slv] into m_dat_r (also on writes), drop s_stb the next cycle, go to RESP.
  - Acks on non-selected slaves are ignored.
- RESP: m_ack=1 for exactly one cycle, then IDLE.
- ERR: m_err=1 for exactly one cycle, m_dat_r=32'h0, then IDLE.
- Latency with a zero-wait slave (s_ack in the first ACCESS cycle): m_stb seen in cycle 0, s_stb high in cycle 1, m_ack in cycle 2. Each slave wait state adds one cycle.
- Address and data are latched in IDLE; master changes after cycle 0 are ignored until the next transaction.
- Abort: m_cyc=0 during ACCESS → s_stb cleared the next cycle, return to IDLE, no m_ack/m_err. A late slave ack after an abort is ignored.
- Back-to-back: a transaction may start in the IDLE cycle immediately after RESP/ERR. Minimum spacing is 3 cycles per access.
- m_ack and m_err are never high together.
- reset asserted mid-transaction: every output returns to 0 on the next edge.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined: a 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle without an ack. When it reaches TIMEOUT_CYC-1 with no ack, s_stb is dropped, state goes to ERR and m_err pulses. An ack arriving in that same cycle wins and gives a normal RESP.
- Undefined: no counter; ACCESS waits indefinitely.

Test Plan:
- Setup for all scenarios: NUM_SLV=4; slave0 base 32'h03400500 mask 32'hFFFFFF00 (XBUS); slave1 32'h03300000/32'hFFFF0000 (MADAM); slave2 32'h03400000/32'hFFFF0000 (CLIO); slave3 mask 0 (default).
- Read 32'h03400504, slave0 returns 32'h12345678 with 0 wait states → s_stb=4'b0001, cur_slv=0, m_ack in cycle 2, m_dat_r=32'h12345678. Confirms priority over CLIO.
- Write 32'h03300010 data 32'hCAFEF00D sel 4'hF, slave1 acks after 3 wait states → s_adr/s_dat_w stable throughout, m_ack in cycle 5, exactly one pulse.
- Read 32'h00001000 → routed to slave3 (default). Repeat with slave3 mask set to 32'hFFFFFFFF base 32'h0 → ERR: m_err pulse in cycle 1, m_dat_r=0, no s_stb.
- Abort: read to slave2, drop m_cyc in cycle 2 before any ack, slave2 acks in cycle 3 → no m_ack/m_err; s_stb=0 from cycle 3.
- With BUS_TIMEOUT_EN, TIMEOUT_CYC=8: slave1 never acks → s_stb high for 8 cycles, then m_err pulse; state IDLE afterwards. Without the macro, s_stb stays high after 100 cycles.
- Reset asserted during ACCESS → s_stb, m_ack, m_err, cur_slv all 0 after the next edge; a following read to slave2 completes normally.
